i2c_scl_timing_gen: RTL and testbench

Parametrised SCL generator for the I2C master, replacing the fixed 100 kHz divider and the enable-gated SCL buffer. It adds a runtime standard/fast speed select and open-drain drive control, and honours slave clock stretching with a timeout. It also emits phase strobes that the master bit engine uses to change SDA (mid-low) and sample SDA (mid-high). It sits between the master FSM and the SCL pad.

---
 rtl/i2c_scl_timing_gen.sv | 180 ++++++++++++++++++
 tb/tb_i2c_scl_timing_gen.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_scl_timing_gen.sv
// SCL generator for the I2C master. It provides a standard/fast rate select and open-drain drive,
// tracks slave clock stretching with a timeout, and issues mid-LOW/mid-HIGH strobes for the bit engine.
module i2c_scl_timing_gen #(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int SCL_STD_HZ  = 100_000,
   parameter int SCL_FAST_HZ = 400_000,
   parameter int TIMEOUT_CYC = 1_250_000
) (
   input  logic fpga_clock,
   input  logic fpga_rst_n,
   input  logic scl_en,
   input  logic fast_mode,
   input  logic scl_in,
   output logic scl_drive_low,
   output logic scl_rise_stb,
   output logic scl_fall_stb,
   output logic change_stb,
   output logic sample_stb,
   output logic stretching,
   output logic stretch_timeout,
   output logic busy
);
   // state     | meaning
   // IDLE      | SCL released, waiting for scl_en
   // LOW       | master drives SCL low for HALF cycles
   // HIGH_WAIT | SCL released, waiting for the pad to read high (stretch)
   // HIGH      | SCL high, HALF-2 cycles (HIGH_WAIT covers the other 2)
   // ERR       | stretch timed out, SCL released until scl_en drops
   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOW   = 3'd1;
   localparam logic [2:0] S_HWAIT = 3'd2;
   localparam logic [2:0] S_HIGH  = 3'd3;
   localparam logic [2:0] S_ERR   = 3'd4;

   localparam int HALF_STD  = CLK_FREQ_HZ / (2 * SCL_STD_HZ);
   localparam int HALF_FAST = CLK_FREQ_HZ / (2 * SCL_FAST_HZ);
   localparam int HALF_MAX  = (HALF_STD > HALF_FAST) ? HALF_STD : HALF_FAST;
   localparam int CW        = $clog2(HALF_MAX + 1);
   localparam int SW        = $clog2(TIMEOUT_CYC);

   localparam logic [CW-1:0] HALF_STD_W  = CW'(HALF_STD);
   localparam logic [CW-1:0] HALF_FAST_W = CW'(HALF_FAST);
   localparam logic [SW-1:0] STR_LAST    = SW'(TIMEOUT_CYC - 1);

   generate
      if (HALF_STD < 8 || HALF_FAST < 8) begin : g_bad_half
         $error("i2c_scl_timing_gen: half period below 8 clocks");
      end
      if (TIMEOUT_CYC < 4) begin : g_bad_timeout
         $error("i2c_scl_timing_gen: TIMEOUT_CYC below 4");
      end
   endgenerate

   logic [2:0]    state_q, state_d;
   logic          mode_q, mode_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [SW-1:0] str_cnt_q, str_cnt_d;
   logic          scl_meta_q;
   logic [CW-1:0] half_q, half_d;

   logic scl_drive_low_q, scl_drive_low_d;
   logic scl_rise_stb_q, scl_rise_stb_d;
   logic scl_fall_stb_q, scl_fall_stb_d;
   logic change_stb_q, change_stb_d;
   logic sample_stb_q, sample_stb_d;
   logic stretching_q, stretching_d;
   logic stretch_timeout_q, stretch_timeout_d;
   logic busy_q, busy_d;

   assign half_q = mode_q ? HALF_FAST_W : HALF_STD_W;
   assign half_d = mode_d ? HALF_FAST_W : HALF_STD_W;

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      cnt_d     = cnt_q;
      str_cnt_d = str_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (scl_en) begin
               state_d = S_LOW;
               mode_d  = fast_mode;
               cnt_d   = '0;
            end
         end
         S_LOW: begin
            if (cnt_q == half_q - CW'(1)) begin
               state_d   = S_HWAIT;
               cnt_d     = '0;
               str_cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         // scl_meta_q is the first synchroniser stage; the state register is the second,
         // which gives the two-cycle release-to-HIGH latency in loopback.
         S_HWAIT: begin
            if (scl_meta_q) begin
               state_d = S_HIGH;
               cnt_d   = '0;
            end else if (str_cnt_q == STR_LAST) begin
               state_d = S_ERR;
            end else begin
               str_cnt_d = str_cnt_q + SW'(1);
            end
         end
         S_HIGH: begin
            if (cnt_q == half_q - CW'(3)) begin
               cnt_d = '0;
               if (scl_en) begin
                  state_d = S_LOW;
                  mode_d  = fast_mode;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_ERR: begin
            if (!scl_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so each strobe lands in the first cycle of its state.
   always_comb begin
      scl_drive_low_d   = (state_d == S_LOW);
      scl_fall_stb_d    = (state_d == S_LOW) && (cnt_d == '0);
      change_stb_d      = (state_d == S_LOW) && (cnt_d == (half_d >> 1));
      scl_rise_stb_d    = (state_d == S_HIGH) && (cnt_d == '0);
      sample_stb_d      = (state_d == S_HIGH) && (cnt_d == ((half_d - CW'(2)) >> 1));
      stretching_d      = (state_d == S_HWAIT) && (str_cnt_d >= SW'(2));
      stretch_timeout_d = (state_d == S_ERR);
      busy_d            = (state_d == S_LOW) || (state_d == S_HWAIT) || (state_d == S_HIGH);
   end

   always_ff @(posedge fpga_clock or negedge fpga_rst_n) begin
      if (!fpga_rst_n) begin
         state_q           <= S_IDLE;
         mode_q            <= 1'b0;
         cnt_q             <= '0;
         str_cnt_q         <= '0;
         scl_meta_q        <= 1'b1;
         scl_drive_low_q   <= 1'b0;
         scl_rise_stb_q    <= 1'b0;
         scl_fall_stb_q    <= 1'b0;
         change_stb_q      <= 1'b0;
         sample_stb_q      <= 1'b0;
         stretching_q      <= 1'b0;
         stretch_timeout_q <= 1'b0;
         busy_q            <= 1'b0;
      end else begin
         state_q           <= state_d;
         mode_q            <= mode_d;
         cnt_q             <= cnt_d;
         str_cnt_q         <= str_cnt_d;
         scl_meta_q        <= scl_in;
         scl_drive_low_q   <= scl_drive_low_d;
         scl_rise_stb_q    <= scl_rise_stb_d;
         scl_fall_stb_q    <= scl_fall_stb_d;
         change_stb_q      <= change_stb_d;
         sample_stb_q      <= sample_stb_d;
         stretching_q      <= stretching_d;
         stretch_timeout_q <= stretch_timeout_d;
         busy_q            <= busy_d;
      end
   end

   assign scl_drive_low   = scl_drive_low_q;
   assign scl_rise_stb    = scl_rise_stb_q;
   assign scl_fall_stb    = scl_fall_stb_q;
   assign change_stb      = change_stb_q;
   assign sample_stb      = sample_stb_q;
   assign stretching      = stretching_q;
   assign stretch_timeout = stretch_timeout_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_i2c_scl_timing_gen.sv
// Bench for i2c_scl_timing_gen: a period-level timing model predicts every strobe and level edge by cycle number;
// a negedge monitor pops those predictions and compares them with what the DUT shows.
module tb_i2c_scl_timing_gen;
   localparam int TMO    = 1500;
   localparam int H_STD  = 250;
   localparam int H_FAST = 62;

   localparam int K_FALL     = 0;
   localparam int K_CHANGE   = 1;
   localparam int K_RISE     = 2;
   localparam int K_SAMPLE   = 3;
   localparam int K_DRV_ON   = 4;
   localparam int K_DRV_REL  = 5;
   localparam int K_STR_ON   = 6;
   localparam int K_STR_OFF  = 7;
   localparam int K_TMO_ON   = 8;
   localparam int K_TMO_OFF  = 9;
   localparam int K_BUSY_ON  = 10;
   localparam int K_BUSY_OFF = 11;

   logic fpga_clock = 1'b0;
   logic fpga_rst_n = 1'b1;
   logic scl_en     = 1'b0;
   logic fast_mode  = 1'b0;
   logic slave_low  = 1'b0;
   logic scl_in;
   logic scl_drive_low, scl_rise_stb, scl_fall_stb, change_stb, sample_stb;
   logic stretching, stretch_timeout, busy;

   assign scl_in = ~(scl_drive_low | slave_low);

   i2c_scl_timing_gen #(
      .CLK_FREQ_HZ (50_000_000),
      .SCL_STD_HZ  (100_000),
      .SCL_FAST_HZ (400_000),
      .TIMEOUT_CYC (TMO)
   ) dut (
      .fpga_clock      (fpga_clock),
      .fpga_rst_n      (fpga_rst_n),
      .scl_en          (scl_en),
      .fast_mode       (fast_mode),
      .scl_in          (scl_in),
      .scl_drive_low   (scl_drive_low),
      .scl_rise_stb    (scl_rise_stb),
      .scl_fall_stb    (scl_fall_stb),
      .change_stb      (change_stb),
      .sample_stb      (sample_stb),
      .stretching      (stretching),
      .stretch_timeout (stretch_timeout),
      .busy            (busy)
   );

   always #5 fpga_clock = ~fpga_clock;

   int cyc = 0;
   always @(posedge fpga_clock) cyc <= cyc + 1;

   int vectors = 0;
   int miscompares = 0;
   longint exp_q[$];
   longint pend_q[$];

   function automatic string kname(input int k);
      case (k)
         K_FALL:     return "fall_stb";
         K_CHANGE:   return "change_stb";
         K_RISE:     return "rise_stb";
         K_SAMPLE:   return "sample_stb";
         K_DRV_ON:   return "drive_low_on";
         K_DRV_REL:  return "drive_low_off";
         K_STR_ON:   return "stretching_on";
         K_STR_OFF:  return "stretching_off";
         K_TMO_ON:   return "timeout_on";
         K_TMO_OFF:  return "timeout_off";
         K_BUSY_ON:  return "busy_on";
         K_BUSY_OFF: return "busy_off";
         default:    return "unknown";
      endcase
   endfunction

   task automatic add(input int c, input int k);
      pend_q.push_back(longint'(c) * 16 + longint'(k));
   endtask

   task automatic flush();
      pend_q.sort();
      foreach (pend_q[i]) exp_q.push_back(pend_q[i]);
      pend_q.delete();
   endtask

   task automatic goto(input int c);
      while (cyc < c) begin
         @(posedge fpga_clock);
         #1;
      end
   endtask

   task automatic chk_evt(input int kind, input logic hit);
      longint got, want;
      if (hit) begin
         got = longint'(cyc) * 16 + longint'(kind);
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL event: got %s @cycle %0d, required no event", kname(kind), cyc);
         end else begin
            want = exp_q.pop_front();
            if (want != got) begin
               miscompares++;
               $display("FAIL event: got %s @cycle %0d, required %s @cycle %0d",
                        kname(kind), cyc, kname(int'(want % 16)), int'(want / 16));
            end
         end
      end
   endtask

   task automatic check_eq(input string name, input logic act, input logic req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got %b, required %b", name, act, req);
      end
   endtask

   // Monitor: level edges and strobes, in the same within-cycle order as the model's sort key
   logic p_drv = 1'b0, p_str = 1'b0, p_tmo = 1'b0, p_busy = 1'b0;
   initial begin
      forever begin
         @(negedge fpga_clock);
         chk_evt(K_FALL,     scl_fall_stb);
         chk_evt(K_CHANGE,   change_stb);
         chk_evt(K_RISE,     scl_rise_stb);
         chk_evt(K_SAMPLE,   sample_stb);
         chk_evt(K_DRV_ON,   scl_drive_low & ~p_drv);
         chk_evt(K_DRV_REL,  ~scl_drive_low & p_drv);
         chk_evt(K_STR_ON,   stretching & ~p_str);
         chk_evt(K_STR_OFF,  ~stretching & p_str);
         chk_evt(K_TMO_ON,   stretch_timeout & ~p_tmo);
         chk_evt(K_TMO_OFF,  ~stretch_timeout & p_tmo);
         chk_evt(K_BUSY_ON,  busy & ~p_busy);
         chk_evt(K_BUSY_OFF, ~busy & p_busy);
         p_drv  = scl_drive_low;
         p_str  = stretching;
         p_tmo  = stretch_timeout;
         p_busy = busy;
      end
   end

   // One SCL period starting (fall) at cycle t0, with n cycles of slave stretch; e = next period start
   task automatic run_period(input int t0, input bit m, input bit mnext, input int n,
                             input bit cont, input bit glitch, input bit first, output int e);
      int h, r;
      h = m ? H_FAST : H_STD;
      r = t0 + h + 2 + n;
      e = t0 + 2 * h + n;
      add(t0, K_FALL);
      add(t0, K_DRV_ON);
      if (first) add(t0, K_BUSY_ON);
      add(t0 + h / 2, K_CHANGE);
      add(t0 + h, K_DRV_REL);
      if (n > 0) begin
         add(t0 + h + 2, K_STR_ON);
         add(r, K_STR_OFF);
      end
      add(r, K_RISE);
      add(r + (h - 2) / 2, K_SAMPLE);
      if (!cont) add(e, K_BUSY_OFF);
      flush();
      goto(t0 + 1);
      fast_mode = ~m;
      if (n > 0) slave_low = 1'b1;
      goto(t0 + 10);
      if (!cont || glitch) scl_en = 1'b0;
      if (n > 0) begin
         goto(t0 + h + n);
         slave_low = 1'b0;
      end
      goto(r);
      fast_mode = mnext;
      if (cont) scl_en = 1'b1;
   endtask

   task automatic burst(input int nper, input bit m0, input bit rnd_mode, input int fixed_n, input int gap);
      bit m, mn, cont, gl;
      int t0, e, n;
      m = m0;
      fast_mode = m0;
      scl_en = 1'b1;
      t0 = cyc + 1;
      e = t0;
      for (int k = 0; k < nper; k++) begin
         cont = (k != nper - 1);
         mn = rnd_mode ? 1'($urandom_range(0, 1)) : m;
         if (fixed_n >= 0) n = fixed_n;
         else if ($urandom_range(0, 3) == 0) n = int'($urandom_range(1, 400));
         else n = 0;
         gl = cont && ($urandom_range(0, 3) == 0);
         run_period(t0, m, mn, n, cont, gl, (k == 0), e);
         t0 = e;
         m = mn;
      end
      goto(e + gap);
   endtask

   task automatic timeout_case();
      int t0, te;
      fast_mode = 1'b0;
      scl_en = 1'b1;
      t0 = cyc + 1;
      te = t0 + H_STD + TMO;
      add(t0, K_FALL);
      add(t0, K_DRV_ON);
      add(t0, K_BUSY_ON);
      add(t0 + H_STD / 2, K_CHANGE);
      add(t0 + H_STD, K_DRV_REL);
      add(t0 + H_STD + 2, K_STR_ON);
      add(te, K_STR_OFF);
      add(te, K_TMO_ON);
      add(te, K_BUSY_OFF);
      flush();
      goto(t0 + 1);
      slave_low = 1'b1;
      goto(te + 30);
      check_eq("timeout_level", stretch_timeout, 1'b1);
      check_eq("timeout_released", scl_drive_low, 1'b0);
      scl_en = 1'b0;
      add(te + 31, K_TMO_OFF);
      flush();
      goto(te + 33);
      slave_low = 1'b0;
      goto(te + 40);
   endtask

   task automatic reset_case();
      int t0;
      fast_mode = 1'b0;
      scl_en = 1'b1;
      t0 = cyc + 1;
      add(t0, K_FALL);
      add(t0, K_DRV_ON);
      add(t0, K_BUSY_ON);
      flush();
      goto(t0 + 20);
      #2;
      fpga_rst_n = 1'b0;
      scl_en = 1'b0;
      add(t0 + 20, K_DRV_REL);
      add(t0 + 20, K_BUSY_OFF);
      flush();
      #1;
      check_eq("async_rst_drive", scl_drive_low, 1'b0);
      check_eq("async_rst_fall", scl_fall_stb, 1'b0);
      check_eq("async_rst_change", change_stb, 1'b0);
      check_eq("async_rst_busy", busy, 1'b0);
      goto(t0 + 25);
      fpga_rst_n = 1'b1;
      goto(t0 + 60);
   endtask

   initial begin
      #1 fpga_rst_n = 1'b0;
      #3;
      check_eq("rst_drive", scl_drive_low, 1'b0);
      check_eq("rst_rise", scl_rise_stb, 1'b0);
      check_eq("rst_fall", scl_fall_stb, 1'b0);
      check_eq("rst_change", change_stb, 1'b0);
      check_eq("rst_sample", sample_stb, 1'b0);
      check_eq("rst_stretching", stretching, 1'b0);
      check_eq("rst_timeout", stretch_timeout, 1'b0);
      check_eq("rst_busy", busy, 1'b0);
      goto(4);
      fpga_rst_n = 1'b1;
      goto(20);
      burst(3, 1'b0, 1'b0, 0, 0);
      burst(3, 1'b1, 1'b0, 0, 3);
      burst(1, 1'b0, 1'b0, 1000, 2);
      timeout_case();
      reset_case();
      for (int i = 0; i < 6; i++)
         burst(3, 1'($urandom_range(0, 1)), 1'b1, -1, int'($urandom_range(0, 5)));
      goto(cyc + 20);
      check_eq("end_drive", scl_drive_low, 1'b0);
      check_eq("end_busy", busy, 1'b0);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL missing events: got %0d outstanding, required 0 (next %s @cycle %0d)",
                  exp_q.size(), kname(int'(exp_q[0] % 16)), int'(exp_q[0] / 16));
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
